adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Amplitude envelope stage between the sine generator and the pair of PWM DACs in the melody player.
- Scales the positive and negative half-wave samples by an 8-bit envelope level, so each tone has attack, decay, sustain and release instead of hard on/off edges.
- The note sequencer drives `gate` high for the length of each tone.
- The envelope steps once per sample tick (fs = 8 kHz strobe from the fs clock generator).

Parameters:
- N, 8, sample bitwidth (matches the DAC width).
- E, 8, envelope level width. The level range is 0..2^E-1.

Ports:
- clk  in  1  system clock (1 MHz)
- reset  in  1  synchronous, active-high
- sample_en  in  1  one-cycle strobe at fs; envelope step and output update happen on this strobe
- gate  in  1  note active level from the sequencer
- retrig  in  1  one-cycle pulse; restarts the attack while `gate`=1
- attack_inc  in  E  level added per tick in ATTACK
- decay_dec  in  E  level subtracted per tick in DECAY
- sustain_lvl  in  E  SUSTAIN level
- release_dec  in  E  level subtracted per tick in RELEASE
- pos_in  in  N  positive half-wave sample
- neg_in  in  N  negative half-wave sample
- pos_out  out  N  scaled positive sample, to the DAC `t_on`
- neg_out  out  N  scaled negative sample, to the DAC `t_on`
- out_valid  out  1  one-cycle pulse when `pos_out`/`neg_out` update
- env_level  out  E  current envelope level
- busy  out  1  high when state != IDLE

Behaviour:
- **Reset:**
  - state=IDLE, env_level=0, pos_out=0, neg_out=0, out_valid=0, gate_d=0.
  - Reset mid-note returns to IDLE on the next edge with no release phase.
  - Because gate_d resets to 0, a gate held high through reset is seen as a rising edge on the first cycle after reset.
- **Gate edge detection:**
  - gate_d is registered every clk.
  - rise = gate & ~gate_d.
  - fall = ~gate & gate_d.
- **States:** IDLE, ATTACK, DECAY, SUSTAIN, RELEASE (3-bit encoding).
- **Event transitions** (evaluated every clk, not only on ticks):
  - rise, or retrig with gate=1, from any state -> ATTACK. The level is not reset; attack starts from the current level.
  - fall in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - retrig with gate=0 is ignored.
  - If rise/retrig and fall coincide, fall wins.
  - Any cycle with a transition event skips the envelope step, even if `sample_en`=1.
- **Tick steps** (when `sample_en`=1 and there is no event; arithmetic is E+1 bits with saturation):
  - IDLE: level stays 0.
  - ATTACK: level = min(2^E-1, level+attack_inc). When the result equals 2^E-1 -> DECAY. attack_inc=0 jumps straight to 2^E-1.
  - DECAY: level = max(sustain_lvl, level-decay_dec). When the result equals sustain_lvl -> SUSTAIN. decay_dec=0 jumps straight to sustain_lvl.
  - SUSTAIN: level = sustain_lvl. Runtime changes to sustain_lvl are tracked on each tick.
  - RELEASE: level = max(0, level-release_dec). When the result is 0 -> IDLE. release_dec=0 jumps straight to 0.
- **Output scaling:**
  - On a `sample_en` cycle, pos_out/neg_out are registered and `out_valid`=1 on the following cycle. Latency is 1 clk.
  - Computation: out = (in * level) >> E, using an N+E-bit product.
  - level = 2^E-1 bypasses scaling, so out = in exactly.
  - The multiply uses the level as registered before that tick's step.
  - Between strobes the outputs hold their values and `out_valid`=0.
- **Combinational outputs:** busy and env_level are direct decodes of the state and level registers.

Test Plan:
- Reset, then gate=1 with attack_inc=32 and ticks every 125 clk -> level sequence 32, 64, …, 224, 255 (8 ticks), then state=DECAY.
- From 255 in DECAY, decay_dec=16 and sustain_lvl=128 -> 239, 223, …, 143, then 128 (clamped) on the 8th tick; state=SUSTAIN; sustain_lvl changed to 100 -> level=100 at the next tick.
- Level 128 with pos_in=200 and neg_in=0 -> one clk after sample_en, pos_out=100, neg_out=0, out_valid a single-cycle pulse.
- Level 255 with pos_in=255 -> pos_out=255 (bypass).
- In SUSTAIN at level 128, gate falls on the same cycle as sample_en with release_dec=64 -> no step that cycle; RELEASE; next ticks give 64, then 0; IDLE; busy=0.
- Gate falls during ATTACK at level 96, then rise two ticks later -> ATTACK resumes from the current release level, not from 0. Separately: retrig with gate=0 -> no change; reset asserted in DECAY -> IDLE, level 0, outputs 0 next cycle.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: steps an E-bit level once per sample strobe and
// scales the positive/negative half-wave samples by that level.
module adsr_envelope #(
  parameter int N = 8,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_en,
  input  logic         gate,
  input  logic         retrig,
  input  logic [E-1:0] attack_inc,
  input  logic [E-1:0] decay_dec,
  input  logic [E-1:0] sustain_lvl,
  input  logic [E-1:0] release_dec,
  input  logic [N-1:0] pos_in,
  input  logic [N-1:0] neg_in,
  output logic [N-1:0] pos_out,
  output logic [N-1:0] neg_out,
  output logic         out_valid,
  output logic [E-1:0] env_level,
  output logic         busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [E-1:0] LVL_MAX  = {E{1'b1}};
  localparam logic [E-1:0] LVL_ZERO = {E{1'b0}};

  state_e       state_q;
  logic [E-1:0] level_q;
  logic         gate_q;
  logic [N-1:0] pos_q;
  logic [N-1:0] neg_q;
  logic         valid_q;

  logic         rise, fall, in_note, fall_ev, start_ev;
  logic [E:0]   att_sum, dec_diff, rel_diff;
  logic [E-1:0] att_next, dec_next, rel_next;

  // Full level bypasses the multiply so a full-scale envelope is lossless.
  function automatic logic [N-1:0] scale(input logic [N-1:0] x, input logic [E-1:0] lvl);
    logic [N+E-1:0] prod;
    prod = {{E{1'b0}}, x} * {{N{1'b0}}, lvl};
    if (lvl == LVL_MAX) scale = x;
    else                scale = prod[N+E-1:E];
  endfunction

  assign rise     = gate & ~gate_q;
  assign fall     = ~gate & gate_q;
  assign in_note  = (state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN);
  assign fall_ev  = fall & in_note;
  assign start_ev = rise | (retrig & gate);

  // Saturating E+1-bit step arithmetic; a zero rate jumps straight to the target.
  assign att_sum  = {1'b0, level_q} + {1'b0, attack_inc};
  assign att_next = ((attack_inc == LVL_ZERO) || att_sum[E]) ? LVL_MAX : att_sum[E-1:0];
  assign dec_diff = {1'b0, level_q} - {1'b0, decay_dec};
  assign dec_next = ((decay_dec == LVL_ZERO) || dec_diff[E] || (dec_diff[E-1:0] < sustain_lvl))
                    ? sustain_lvl : dec_diff[E-1:0];
  assign rel_diff = {1'b0, level_q} - {1'b0, release_dec};
  assign rel_next = ((release_dec == LVL_ZERO) || rel_diff[E]) ? LVL_ZERO : rel_diff[E-1:0];

  // Envelope FSM, gate edge register and registered sample outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= LVL_ZERO;
      gate_q  <= 1'b0;
      pos_q   <= {N{1'b0}};
      neg_q   <= {N{1'b0}};
      valid_q <= 1'b0;
    end else begin
      gate_q  <= gate;
      valid_q <= sample_en;
      if (sample_en) begin
        pos_q <= scale(pos_in, level_q);
        neg_q <= scale(neg_in, level_q);
      end
      if (fall_ev) begin
        state_q <= ST_RELEASE;
      end else if (start_ev) begin
        state_q <= ST_ATTACK;
      end else if (sample_en) begin
        case (state_q)
          ST_IDLE: level_q <= LVL_ZERO;
          ST_ATTACK: begin
            level_q <= att_next;
            if (att_next == LVL_MAX) state_q <= ST_DECAY;
          end
          ST_DECAY: begin
            level_q <= dec_next;
            if (dec_next == sustain_lvl) state_q <= ST_SUSTAIN;
          end
          ST_SUSTAIN: level_q <= sustain_lvl;
          ST_RELEASE: begin
            level_q <= rel_next;
            if (rel_next == LVL_ZERO) state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            level_q <= LVL_ZERO;
          end
        endcase
      end
    end
  end

  assign pos_out   = pos_q;
  assign neg_out   = neg_q;
  assign out_valid = valid_q;
  assign env_level = level_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope scenarios followed by
// randomized gate/tick/rate traffic, all compared against an integer reference model.
module tb_adsr_envelope;

  localparam int TICK_GAP = 125;
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic       clk;
  logic       reset;
  logic       sample_en;
  logic       gate;
  logic       retrig;
  logic [7:0] attack_inc, decay_dec, sustain_lvl, release_dec;
  logic [7:0] pos_in, neg_in;
  logic [7:0] pos_out, neg_out;
  logic       out_valid;
  logic [7:0] env_level;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ph, m_lvl, m_po, m_no, m_ov, m_gd;

  adsr_envelope #(.N(8), .E(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .gate(gate), .retrig(retrig),
    .attack_inc(attack_inc), .decay_dec(decay_dec), .sustain_lvl(sustain_lvl),
    .release_dec(release_dec), .pos_in(pos_in), .neg_in(neg_in),
    .pos_out(pos_out), .neg_out(neg_out), .out_valid(out_valid),
    .env_level(env_level), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int scl(input int x, input int lvl);
    if (lvl == 255) return x;
    return (x * lvl) / 256;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One clock of the envelope rules, applied to the inputs present at the edge.
  task automatic model_step();
    bit r, f;
    int nl;
    if (reset) begin
      m_ph = P_IDLE; m_lvl = 0; m_po = 0; m_no = 0; m_ov = 0; m_gd = 0;
    end else begin
      r = gate && (m_gd == 0);
      f = !gate && (m_gd != 0);
      if (sample_en) begin
        m_po = scl(int'(pos_in), m_lvl);
        m_no = scl(int'(neg_in), m_lvl);
        m_ov = 1;
      end else begin
        m_ov = 0;
      end
      if (f && (m_ph == P_ATT || m_ph == P_DEC || m_ph == P_SUS)) begin
        m_ph = P_REL;
      end else if (r || (retrig && gate)) begin
        m_ph = P_ATT;
      end else if (sample_en) begin
        case (m_ph)
          P_ATT: begin
            nl = (attack_inc == 0) ? 255 : imin(255, m_lvl + int'(attack_inc));
            m_lvl = nl;
            if (nl == 255) m_ph = P_DEC;
          end
          P_DEC: begin
            nl = (decay_dec == 0) ? int'(sustain_lvl)
                                  : imax(int'(sustain_lvl), m_lvl - int'(decay_dec));
            m_lvl = nl;
            if (nl == int'(sustain_lvl)) m_ph = P_SUS;
          end
          P_SUS: m_lvl = int'(sustain_lvl);
          P_REL: begin
            nl = (release_dec == 0) ? 0 : imax(0, m_lvl - int'(release_dec));
            m_lvl = nl;
            if (nl == 0) m_ph = P_IDLE;
          end
          default: m_lvl = 0;
        endcase
      end
      m_gd = gate ? 1 : 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("level", env_level, m_lvl);
    check_eq("busy", busy, (m_ph != P_IDLE) ? 1 : 0);
    check_eq("valid", out_valid, m_ov);
    check_eq("pos", pos_out, m_po);
    check_eq("neg", neg_out, m_no);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Strobe then wait out the rest of the tick period.
  task automatic tick();
    sample_en = 1'b1;
    cycle();
    sample_en = 1'b0;
    idle(TICK_GAP - 1);
  endtask

  function automatic logic [7:0] rnd_rate();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'($urandom_range(100, 255));
    return 8'($urandom_range(1, 40));
  endfunction

  initial begin
    reset = 1'b1; sample_en = 1'b0; gate = 1'b0; retrig = 1'b0;
    attack_inc = 8'd0; decay_dec = 8'd0; sustain_lvl = 8'd0; release_dec = 8'd0;
    pos_in = 8'd0; neg_in = 8'd0;
    m_ph = P_IDLE; m_lvl = 0; m_po = 0; m_no = 0; m_ov = 0; m_gd = 0;

    idle(2);
    check_eq("rst_level", env_level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pos", pos_out, 0);
    check_eq("rst_valid", out_valid, 0);
    reset = 1'b0;

    // attack at 32 per tick
    attack_inc = 8'd32; decay_dec = 8'd16; sustain_lvl = 8'd128; release_dec = 8'd64;
    pos_in = 8'd200; neg_in = 8'd0;
    gate = 1'b1;
    cycle();
    check_eq("rise_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("att_seq", env_level, 32 * k);
    end
    // level 128: 200*128>>8 = 100, single-cycle valid
    sample_en = 1'b1;
    cycle();
    sample_en = 1'b0;
    check_eq("scale_pos", pos_out, 100);
    check_eq("scale_neg", neg_out, 0);
    check_eq("scale_valid", out_valid, 1);
    cycle();
    check_eq("valid_pulse", out_valid, 0);
    check_eq("pos_hold", pos_out, 100);
    idle(TICK_GAP - 2);
    for (int k = 6; k <= 8; k++) begin
      tick();
      check_eq("att_seq", env_level, (32 * k > 255) ? 255 : 32 * k);
    end

    // decay from 255 toward 128; first decay tick multiplies by 255 (bypass)
    pos_in = 8'd255;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) check_eq("bypass", pos_out, 255);
      check_eq("dec_seq", env_level, (k == 8) ? 128 : 255 - 16 * k);
    end
    sustain_lvl = 8'd100;
    tick();
    check_eq("sus_track", env_level, 100);
    sustain_lvl = 8'd128;
    tick();
    check_eq("sus_back", env_level, 128);

    // gate fall coinciding with a strobe: no step that cycle
    gate = 1'b0;
    sample_en = 1'b1;
    cycle();
    sample_en = 1'b0;
    check_eq("fall_skip", env_level, 128);
    check_eq("fall_busy", busy, 1);
    idle(TICK_GAP - 1);
    tick();
    check_eq("rel_1", env_level, 64);
    tick();
    check_eq("rel_2", env_level, 0);
    check_eq("rel_idle", busy, 0);

    // release then re-attack resumes from the current level
    release_dec = 8'd16;
    gate = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) tick();
    check_eq("att96", env_level, 96);
    gate = 1'b0;
    cycle();
    tick();
    tick();
    check_eq("rel64", env_level, 64);
    gate = 1'b1;
    cycle();
    tick();
    check_eq("resume", env_level, 96);

    // retrig while gate is low does nothing
    gate = 1'b0;
    cycle();
    tick();
    check_eq("rel80", env_level, 80);
    retrig = 1'b1;
    cycle();
    retrig = 1'b0;
    tick();
    check_eq("retrig_ign", env_level, 64);
    check_eq("retrig_busy", busy, 1);

    // reset while in decay
    gate = 1'b1;
    attack_inc = 8'd0;
    cycle();
    tick();
    check_eq("att_jump", env_level, 255);
    decay_dec = 8'd1;
    tick();
    check_eq("dec_1", env_level, 254);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("mid_rst_level", env_level, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_pos", pos_out, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    gate = 1'b0;
    idle(3);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      sample_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      retrig = ($urandom_range(0, 49) == 0);
      reset  = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 99) == 0) begin
        attack_inc  = rnd_rate();
        decay_dec   = rnd_rate();
        release_dec = rnd_rate();
        sustain_lvl = 8'($urandom_range(0, 255));
      end
      pos_in = 8'($urandom_range(0, 255));
      neg_in = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
